// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the scoreboard slice.
package rf_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback/flush bundle between the core pipeline and the register-file scoreboard.
interface rf_scoreboard_if;
  import rf_pkg::*;

  logic                issue_valid;
  logic                issue_rs_used;
  reg_idx_t            issue_rs_reg;
  logic                issue_rt_used;
  reg_idx_t            issue_rt_reg;
  logic                issue_wr_en;
  reg_idx_t            issue_wr_reg;
  logic                issue_stall;
  logic                issue_fire;
  logic                wb_en;
  reg_idx_t            wb_reg;
  logic                flush;
  logic [NUM_REGS-1:0] busy_mask;
  logic                sb_err;

  modport master (
    output issue_valid, issue_rs_used, issue_rs_reg, issue_rt_used, issue_rt_reg,
           issue_wr_en, issue_wr_reg, wb_en, wb_reg, flush,
    input  issue_stall, issue_fire, busy_mask, sb_err
  );

  modport slave (
    input  issue_valid, issue_rs_used, issue_rs_reg, issue_rt_used, issue_rt_reg,
           issue_wr_en, issue_wr_reg, wb_en, wb_reg, flush,
    output issue_stall, issue_fire, busy_mask, sb_err
  );

endinterface

// File: rtl/rf_sb_counter.sv
// Per-register pending-write counter: up on issue, down on retire, cleared by flush.
module rf_sb_counter #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel, so a retire on an empty counter is not an error then.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: stalls decode on pending source writes or a saturated destination.
// Optional macro RF_SB_WB_BYPASS_EN lets a same-cycle retire clear the hazard for stall evaluation.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic            clk,
  input  logic            rst,
  rf_scoreboard_if.slave  sb
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v, nonzero_v, full_v, underflow_v;
  logic                rs_hit, rt_hit, wr_full;
  logic                sb_err_q, sb_err_d;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_v[i] = sb.issue_fire && sb.issue_wr_en && (sb.issue_wr_reg == reg_idx_t'(i));
      dec_v[i] = sb.wb_en && (sb.wb_reg == reg_idx_t'(i));
    end
  end

`ifdef RF_SB_WB_BYPASS_EN
  // A last pending write retiring this cycle is visible through the register-file bypass.
  assign rs_hit  = sb.issue_rs_used && (cnt[sb.issue_rs_reg] != '0) &&
                   !((cnt[sb.issue_rs_reg] == CNT_W'(1)) && dec_v[sb.issue_rs_reg]);
  assign rt_hit  = sb.issue_rt_used && (cnt[sb.issue_rt_reg] != '0) &&
                   !((cnt[sb.issue_rt_reg] == CNT_W'(1)) && dec_v[sb.issue_rt_reg]);
  assign wr_full = sb.issue_wr_en && full_v[sb.issue_wr_reg] && !dec_v[sb.issue_wr_reg];
`else
  assign rs_hit  = sb.issue_rs_used && (cnt[sb.issue_rs_reg] != '0);
  assign rt_hit  = sb.issue_rt_used && (cnt[sb.issue_rt_reg] != '0);
  assign wr_full = sb.issue_wr_en && full_v[sb.issue_wr_reg];
`endif

  assign sb.issue_stall = sb.issue_valid && (rs_hit || rt_hit || wr_full);
  assign sb.issue_fire  = sb.issue_valid && !sb.issue_stall;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    rf_sb_counter #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (sb.flush),
      .inc       (inc_v[g]),
      .dec       (dec_v[g]),
      .cnt       (cnt[g]),
      .nonzero   (nonzero_v[g]),
      .full      (full_v[g]),
      .underflow (underflow_v[g])
    );
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (!sb.flush && (underflow_v != '0)) sb_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  // Counter flops already hold the next-state value, so the mask is a direct decode of them.
  assign sb.busy_mask = nonzero_v;
  assign sb.sb_err    = sb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: per-cycle model compare plus directed literal checks.
module tb_rf_scoreboard;

  localparam int MAXF = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  rf_scoreboard_if sb_if ();

  rf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(MAXF)) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: pending-write counts per register and the sticky error flag.
  int m_cnt [8];
  bit m_err;
  int n_cnt [8];
  bit n_err;

  function automatic bit src_hit(input bit used, input int r);
    bit retiring = sb_if.wb_en && (int'(sb_if.wb_reg) == r);
`ifdef RF_SB_WB_BYPASS_EN
    return used && (m_cnt[r] - (retiring ? 1 : 0) > 0);
`else
    return used && (m_cnt[r] > 0) && (retiring || !retiring);
`endif
  endfunction

  function automatic bit dst_full(input bit wr_en, input int r);
    bit retiring = sb_if.wb_en && (int'(sb_if.wb_reg) == r);
`ifdef RF_SB_WB_BYPASS_EN
    return wr_en && (m_cnt[r] - (retiring ? 1 : 0) == MAXF);
`else
    return wr_en && (m_cnt[r] == MAXF) && (retiring || !retiring);
`endif
  endfunction

  always @(negedge clk) begin
    if (started) begin
      bit exp_stall, exp_fire;
      int exp_busy;
      exp_stall = sb_if.issue_valid &&
                  (src_hit(sb_if.issue_rs_used, int'(sb_if.issue_rs_reg)) ||
                   src_hit(sb_if.issue_rt_used, int'(sb_if.issue_rt_reg)) ||
                   dst_full(sb_if.issue_wr_en, int'(sb_if.issue_wr_reg)));
      exp_fire = sb_if.issue_valid && !exp_stall;
      exp_busy = 0;
      for (int i = 0; i < 8; i++) if (m_cnt[i] != 0) exp_busy += (1 << i);
      check("model_stall", int'(sb_if.issue_stall), int'(exp_stall));
      check("model_fire", int'(sb_if.issue_fire), int'(exp_fire));
      check("model_busy", int'(sb_if.busy_mask), exp_busy);
      check("model_err", int'(sb_if.sb_err), int'(m_err));

      n_err = m_err;
      for (int i = 0; i < 8; i++) begin
        bit inc, dec;
        inc = exp_fire && sb_if.issue_wr_en && (int'(sb_if.issue_wr_reg) == i);
        dec = sb_if.wb_en && (int'(sb_if.wb_reg) == i);
        n_cnt[i] = m_cnt[i];
        if (rst || sb_if.flush) n_cnt[i] = 0;
        else if (inc && !dec)   n_cnt[i] = m_cnt[i] + 1;
        else if (dec && !inc) begin
          if (m_cnt[i] > 0) n_cnt[i] = m_cnt[i] - 1;
          else              n_err = 1'b1;
        end
      end
      if (rst) n_err = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (started) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = n_cnt[i];
      m_err = n_err;
    end
  end

  task automatic idle();
    sb_if.issue_valid   = 1'b0;
    sb_if.issue_rs_used = 1'b0;
    sb_if.issue_rs_reg  = '0;
    sb_if.issue_rt_used = 1'b0;
    sb_if.issue_rt_reg  = '0;
    sb_if.issue_wr_en   = 1'b0;
    sb_if.issue_wr_reg  = '0;
    sb_if.wb_en         = 1'b0;
    sb_if.wb_reg        = '0;
    sb_if.flush         = 1'b0;
  endtask

  task automatic issue(input bit rs_u, input int rs, input bit rt_u, input int rt,
                       input bit wr_e, input int wr);
    sb_if.issue_valid   = 1'b1;
    sb_if.issue_rs_used = rs_u;
    sb_if.issue_rs_reg  = 3'(rs);
    sb_if.issue_rt_used = rt_u;
    sb_if.issue_rt_reg  = 3'(rt);
    sb_if.issue_wr_en   = wr_e;
    sb_if.issue_wr_reg  = 3'(wr);
  endtask

  task automatic retire(input int r);
    sb_if.wb_en  = 1'b1;
    sb_if.wb_reg = 3'(r);
  endtask

  // Advance one clock; inputs may be changed right after return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_cnt[i] = 0; n_cnt[i] = 0; end
    m_err = 1'b0; n_err = 1'b0;
    rst = 1'b1;
    idle();
    step(); step();
    started = 1'b1;
    check("reset_busy", int'(sb_if.busy_mask), 0);
    check("reset_err", int'(sb_if.sb_err), 0);
    rst = 1'b0;
    step();

    // Write r3, then a reader of r3 stalls until r3 retires.
    issue(0, 0, 0, 0, 1, 3); step();
    idle(); issue(1, 3, 0, 0, 0, 0); #1;
    check("t1_stall", int'(sb_if.issue_stall), 1);
    check("t1_busy", int'(sb_if.busy_mask), 'h08);
    step();
    idle(); retire(3); step();
    idle(); issue(1, 3, 0, 0, 0, 0); #1;
    check("t1_release_stall", int'(sb_if.issue_stall), 0);
    check("t1_release_busy", int'(sb_if.busy_mask), 'h00);
    step();

    // Saturate r5 at three pending writes.
    idle(); issue(0, 0, 0, 0, 1, 5); step(); step(); step();
    #1;
    check("t2_full_stall", int'(sb_if.issue_stall), 1);
    check("t2_full_fire", int'(sb_if.issue_fire), 0);
    check("t2_busy", int'(sb_if.busy_mask), 'h20);
    step();
    idle(); retire(5); step();
    idle(); issue(0, 0, 0, 0, 1, 5); #1;
    check("t2_refire", int'(sb_if.issue_fire), 1);
    step();
    idle(); retire(5); step(); step(); step();
    idle(); #1;
    check("t2_drained", int'(sb_if.busy_mask), 0);

    // Issue and retire of r2 in the same cycle cancel.
    issue(0, 0, 0, 0, 1, 2); step();
    idle(); issue(0, 0, 0, 0, 1, 2); retire(2); #1;
    check("t3_fire", int'(sb_if.issue_fire), 1);
    step();
    idle(); #1;
    check("t3_busy", int'(sb_if.busy_mask), 'h04);
    check("t3_err", int'(sb_if.sb_err), 0);
    retire(2); step();
    idle();

    // Self-dependency: r3 <- r3 with r3 idle fires; an identical follow-up stalls.
    issue(1, 3, 0, 0, 1, 3); #1;
    check("self_dep_fire", int'(sb_if.issue_fire), 1);
    step();
    #1;
    check("self_dep_stall", int'(sb_if.issue_stall), 1);
    idle(); retire(3); step();
    idle();

    // Retire of an idle register sets the sticky error.
    retire(6); step();
    idle(); #1;
    check("t4_err", int'(sb_if.sb_err), 1);
    check("t4_busy", int'(sb_if.busy_mask), 0);
    step(); step();
    check("t4_err_sticky", int'(sb_if.sb_err), 1);

    // Flush with concurrent issue; sb_err survives flush.
    issue(0, 0, 0, 0, 1, 1); step(); step();
    issue(0, 0, 0, 0, 1, 4); step();
    idle(); #1;
    check("t5_pre_busy", int'(sb_if.busy_mask), 'h12);
    issue(0, 0, 0, 0, 1, 7); sb_if.flush = 1'b1; step();
    idle(); issue(1, 7, 0, 0, 0, 0); #1;
    check("t5_flush_busy", int'(sb_if.busy_mask), 0);
    check("t5_r7_clear", int'(sb_if.issue_stall), 0);
    check("t5_err_kept", int'(sb_if.sb_err), 1);
    step();
    idle(); issue(0, 0, 0, 0, 1, 1); step();
    idle(); issue(0, 0, 0, 0, 1, 7); retire(4); sb_if.flush = 1'b1; rst = 1'b1; step();
    rst = 1'b0; idle(); #1;
    check("t5_rst_busy", int'(sb_if.busy_mask), 0);
    check("t5_rst_err", int'(sb_if.sb_err), 0);
    step();

    // Same-cycle retire of the only pending r3 write against an rt read.
    issue(0, 0, 0, 0, 1, 3); step();
    idle(); issue(0, 0, 1, 3, 0, 0); retire(3); #1;
`ifdef RF_SB_WB_BYPASS_EN
    check("t6_bypass_stall", int'(sb_if.issue_stall), 0);
`else
    check("t6_raw_stall", int'(sb_if.issue_stall), 1);
`endif
    step();
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Tracks in-flight writes to the 8-entry, 16-bit register file for the pipelined core.
- Decode presents each instruction's source registers and destination register. The block raises a stall when a source register has a pending write, or when the destination register's pending-write counter is saturated.
- Writeback releases the pending write in the same cycle it drives the register-file write port.
- A flush clears all tracking.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter.
- MAX_INFLIGHT, 3, maximum pending writes per register; must be <= 2**CNT_W-1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  decode has an instruction attempting to issue this cycle.
- issue_rs_used  in  1  instruction reads rs.
- issue_rs_reg  in  3  rs index.
- issue_rt_used  in  1  instruction reads rt.
- issue_rt_reg  in  3  rt index.
- issue_wr_en  in  1  instruction writes a register.
- issue_wr_reg  in  3  destination index.
- issue_stall  out  1  combinational; instruction must not issue this cycle.
- issue_fire  out  1  combinational; issue_valid & ~issue_stall.
- wb_en  in  1  writeback writes the register file this cycle.
- wb_reg  in  3  writeback register index.
- flush  in  1  squash all in-flight instructions.
- busy_mask  out  8  registered; bit i set iff cnt[i] != 0.
- sb_err  out  1  registered, sticky; a retire occurred with cnt == 0.

Behaviour:
- State: cnt[0..7], each CNT_W bits, plus the sb_err flag.
- Reset, synchronous on posedge clk while rst is high:
  - all cnt = 0, busy_mask = 0, sb_err = 0.
  - rst has priority over flush, issue and retire.
- Stall, combinational from current cnt with no same-cycle retire credit (default build). issue_stall = issue_valid & (rs_hit | rt_hit | wr_full):
  - rs_hit = issue_rs_used & cnt[rs] != 0.
  - rt_hit = issue_rt_used & cnt[rt] != 0.
  - wr_full = issue_wr_en & cnt[wr] == MAX_INFLIGHT.
- Counter update each posedge, when not rst:
  - If flush: all cnt = 0. Issue and retire in the same cycle are ignored. sb_err is unchanged.
  - Otherwise, for each register i:
    - inc = issue_fire & issue_wr_en & wr_reg == i.
    - dec = wb_en & wb_reg == i.
    - inc & ~dec: cnt + 1.
    - dec & ~inc: cnt - 1 if cnt != 0; else cnt stays 0 and sb_err is set.
    - inc & dec: cnt unchanged (no error even if cnt == 0).
- busy_mask is registered from next-state cnt, so it is valid the cycle after the update.
- Latency: an issue that writes register i causes stalls on i starting the next cycle. A retire clears the hazard the next cycle.
- Self-dependency: an instruction whose destination equals a source stalls only on the source's current count. Its own write is not counted.
- No wrap-around: saturation is prevented by the wr_full stall, so cnt never exceeds MAX_INFLIGHT.
- Reset mid-operation drops all counts. The pipeline is required to be reset in the same cycle.

Optional Feature:
- Macro: RF_SB_WB_BYPASS_EN.
- Defined: for stall evaluation, a source register whose cnt == 1 and which is being retired this cycle (wb_en & wb_reg match) is not a hit. This matches a write-before-read register file with an internal bypass. wr_full likewise uses cnt - dec.
- Undefined: stall uses raw cnt only, as specified above. Counter update is identical in both builds.

Decomposition:
- Shared package (rf_pkg):
  - NUM_REGS = 8.
  - REG_IDX_W = 3.
  - DATA_W = 16.
  - typedef for the register index.
- Sub-module rf_sb_counter: one per-register saturating up/down counter.
  - Inputs: inc, dec, clr, rst.
  - Outputs: cnt, nonzero, full, underflow.
  - Eight instances; the top level holds the decode, stall logic and sb_err.

Test Plan:
1. Reset, then issue_valid with wr_en to r3. Next cycle issue reads rs=r3 -> issue_stall=1, busy_mask=0x08. Then wb_en wb_reg=3 -> next cycle issue_stall=0, busy_mask=0x00.
2. Three issues writing r5 with no retire -> cnt[5]=3. Fourth issue writing r5 (reading nothing) -> issue_stall=1, issue_fire=0. Retire r5 -> next cycle fourth issue fires.
3. cnt[2]=1; same cycle issue writing r2 plus wb_en wb_reg=2 -> cnt[2] stays 1, sb_err=0.
4. wb_en wb_reg=6 with cnt[6]=0 -> sb_err=1 and stays 1 until rst; cnt[6] stays 0.
5. cnt[1]=2 and cnt[4]=1, assert flush with a concurrent issue writing r7 -> busy_mask=0x00 next cycle, cnt[7]=0. Repeat with rst and flush together -> all zero.
6. Bypass build: cnt[3]=1, issue reads rt=r3 while wb_en wb_reg=3 -> issue_stall=0. Default build: issue_stall=1.
